dmem_controller: RTL and testbench
==================================

Name: dmem_controller

Overview:
- Multi-cycle data-memory interface for the memory stage of the pipelined DLX.
- Takes load/store requests (address, size, extend, store data) from the memory stage and runs a req/ack transaction on a word-wide, big-endian external data bus.
- Holds the pipeline through the processor-wide stall while a transaction is pending.
- Returns lane-aligned, sign/zero-extended load data to writeback.

Parameters:
- TIMEOUT, 255, cycles in REQ without BusAck before the transaction is aborted.
- TIMEOUT_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Req  input  1  memory stage holds a valid load/store this cycle.
- WE  input  1  1 = store, 0 = load.
- Size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- Ext  input  1  loads: 1 = sign-extend, 0 = zero-extend.
- Addr  input  32  byte address, bit 0 is MSB.
- WData  input  32  store data, right-justified.
- RData  output  32  aligned/extended load data; valid while Done=1.
- Done  output  1  one-cycle pulse; the held request completes this cycle.
- Stall  output  1  freezes IF/DEC/EXE/MEM/WB.
- MisalignErr  output  1  one-cycle pulse; misaligned or illegal-size request.
- BusErr  output  1  one-cycle pulse with Done on timeout.
- BusReq  output  1  registered bus request.
- BusWE  output  1  bus write.
- BusAddr  output  32  word address; bits 30:31 forced to 0.
- BusBE  output  4  byte enables; bit 0 = lane [0:7].
- BusWData  output  32  lane-replicated store data.
- BusAck  input  1  bus completion, one cycle.
- BusRData  input  32  bus read word; valid with BusAck.

Behaviour:
- Reset (async, reset=0): state IDLE.
  - BusReq, BusWE, BusBE, Done, Stall, MisalignErr and BusErr all 0.
  - RData, BusAddr, BusWData and timeout counter all 0.
  - Reset asserted mid-transaction aborts it; BusReq drops immediately.
- States: IDLE, REQ, DONE.
- IDLE, Req=1 and aligned:
  - Latch WE/Size/Ext/Addr/WData.
  - Stall=1 combinationally in that same cycle.
  - Next state REQ; BusReq=1 from the next cycle.
- IDLE, Req=1 and misaligned:
  - Misaligned means half with Addr[31]=1, word with Addr[30:31]≠00, or Size=11.
  - MisalignErr=1 for one cycle; Stall=0, no bus activity, stay IDLE.
- REQ:
  - Stall=1, BusReq=1; the counter increments each cycle.
  - BusAck=1: capture the extracted BusRData (loads) into RData, drop BusReq next cycle, go DONE, clear the counter.
  - Counter reaches TIMEOUT with no ack: drop BusReq, RData=0, go DONE with BusErr=1.
- DONE:
  - Done=1, Stall=0; the pipeline advances at this edge.
  - Next state IDLE. Req is ignored in DONE: it is the request just served.
  - A new Req is evaluated only in the following IDLE cycle.
- Latency: Req seen in cycle 0, earliest BusAck in cycle 1, Done in cycle 2. Minimum stall is 2 cycles (cycles 0–1).
- BusAck outside REQ is ignored.
- Stores: Done pulses with RData=0.
- Byte lanes, big-endian (off = Addr[30:31]):
  - Byte: BE = 1000 >> off; WData[24:31] replicated to all four lanes.
  - Half: off 00 → 1100, off 10 → 0011; WData[16:31] replicated.
  - Word: 1111.
- Load extract:
  - Take the selected lane(s) into RData LSBs.
  - Ext=1 copies the lane MSB into the upper bits; Ext=0 zero-fills.

Decomposition:
- Shared package dlx_mem_pkg holds:
  - size encodings (SZ_BYTE/SZ_HALF/SZ_WORD);
  - the state enum (ST_IDLE/ST_REQ/ST_DONE);
  - BE constants;
  - default TIMEOUT.
- One combinational sub-module, dmem_lane_align: computes BE, replicated store data and extracted/extended load data from (Size, Ext, off, WData, BusRData).
- The FSM and timeout counter stay in dmem_controller.

Test Plan:
- Word load: Addr=0x100, Size=10, BusAck 3 cycles after BusReq, BusRData=0xDEADBEEF → BusAddr=0x100, BE=1111, Stall high 4 cycles, Done one cycle, RData=0xDEADBEEF.
- Byte load, Ext=1: Addr=0x103, BusRData=0x000000F0 → BE=0001, RData=0xFFFFFFF0. Same case with Ext=0 → RData=0x000000F0.
- Half store: Addr=0x202, WData=0x0000ABCD → BusWE=1, BE=0011, BusWData=0xABCDABCD, BusAddr=0x200, Done with RData=0.
- Misaligned: word at 0x102, and Size=11 at 0x100 → MisalignErr one cycle each, Stall=0, BusReq never asserted.
- Timeout: Req load, BusAck held 0 → BusReq drops after TIMEOUT (255) cycles, BusErr and Done pulse together, RData=0, Stall released.
- Reset mid-REQ: reset=0 during the wait → BusReq/Stall drop immediately. After release, a spurious BusAck is ignored and the next Req starts cleanly.

Source files
------------

// File: rtl/dlx_mem_pkg.sv
// Shared definitions for the DLX data-memory path: access-size encodings,
// controller state type, big-endian byte-enable constants and the default
// bus timeout.
package dlx_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } state_e;

    // BusBE[3] enables the most significant lane (byte address offset 0).
    localparam logic [3:0] BE_NONE    = '0;
    localparam logic [3:0] BE_BYTE    = 4'b1000;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_WORD    = '1;

    localparam int unsigned DEF_TIMEOUT = 255;

    // Halves need an even offset, words a zero offset; the 11 size is never legal.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_controller_if.sv
// External word-wide data bus of the DLX memory stage.
//   BusReq/BusWE/BusAddr/BusBE/BusWData : controller -> memory
//   BusAck/BusRData                     : memory -> controller (one-cycle ack)
interface dmem_controller_if;
    logic        BusReq;
    logic        BusWE;
    logic [31:0] BusAddr;
    logic [3:0]  BusBE;
    logic [31:0] BusWData;
    logic        BusAck;
    logic [31:0] BusRData;

    modport master (
        output BusReq, BusWE, BusAddr, BusBE, BusWData,
        input  BusAck, BusRData
    );

    modport slave (
        input  BusReq, BusWE, BusAddr, BusBE, BusWData,
        output BusAck, BusRData
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Big-endian lane steering for the data-memory bus (purely combinational).
//   size_i, ext_i, off_i : access size, sign-extend flag, byte offset in word
//   wdata_i              : right-justified store data
//   bus_rdata_i          : raw bus read word
//   be_o                 : byte enables (bit 3 = lane at offset 0)
//   bus_wdata_o          : store data replicated across all lanes
//   rdata_o              : selected lane(s), right-justified and extended
module dmem_lane_align
    import dlx_mem_pkg::*;
(
    input  size_e       size_i,
    input  logic        ext_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] bus_rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] bus_wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        // Offset 0 is the most significant lane.
        case (off_i)
            2'd0:    lane_byte = bus_rdata_i[31:24];
            2'd1:    lane_byte = bus_rdata_i[23:16];
            2'd2:    lane_byte = bus_rdata_i[15:8];
            default: lane_byte = bus_rdata_i[7:0];
        endcase
        lane_half = off_i[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
    end

    always_comb begin
        be_o        = BE_NONE;
        bus_wdata_o = '0;
        rdata_o     = '0;
        case (size_i)
            SZ_BYTE: begin
                be_o        = BE_BYTE >> off_i;
                bus_wdata_o = {4{wdata_i[7:0]}};
                rdata_o     = {{24{ext_i & lane_byte[7]}}, lane_byte};
            end
            SZ_HALF: begin
                be_o        = off_i[1] ? BE_HALF_LO : BE_HALF_HI;
                bus_wdata_o = {2{wdata_i[15:0]}};
                rdata_o     = {{16{ext_i & lane_half[15]}}, lane_half};
            end
            SZ_WORD: begin
                be_o        = BE_WORD;
                bus_wdata_o = wdata_i;
                rdata_o     = bus_rdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_controller.sv
// Multi-cycle data-memory controller for the DLX memory stage.
//   clk, reset  : rising-edge clock, asynchronous active-low reset
//   Req/WE/Size/Ext/Addr/WData : load/store request from the memory stage
//   RData/Done  : aligned load data, valid during the one-cycle Done pulse
//   Stall       : processor-wide freeze while a transaction is pending
//   MisalignErr : one-cycle pulse for a misaligned / illegal-size request
//   BusErr      : pulses with Done when the bus timed out
//   bus         : req/ack word bus (master side)
module dmem_controller
    import dlx_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Req,
    input  logic              WE,
    input  logic [1:0]        Size,
    input  logic              Ext,
    input  logic [31:0]       Addr,
    input  logic [31:0]       WData,
    output logic [31:0]       RData,
    output logic              Done,
    output logic              Stall,
    output logic              MisalignErr,
    output logic              BusErr,
    dmem_controller_if.master bus
);

    state_e                 state_q, state_d;
    logic                   we_q, we_d;
    size_e                  size_q, size_d;
    logic                   ext_q, ext_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic                   busreq_q, busreq_d;
    logic                   err_q, err_d;
    logic [31:0]            rdata_q, rdata_d;

    logic [3:0]             be;
    logic [31:0]            bus_wdata;
    logic [31:0]            ld_data;
    logic [TIMEOUT_W-1:0]   cnt_inc;

    dmem_lane_align u_align (
        .size_i      (size_q),
        .ext_i       (ext_q),
        .off_i       (addr_q[1:0]),
        .wdata_i     (wdata_q),
        .bus_rdata_i (bus.BusRData),
        .be_o        (be),
        .bus_wdata_o (bus_wdata),
        .rdata_o     (ld_data)
    );

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        ext_d       = ext_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        busreq_d    = busreq_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        Stall       = 1'b0;
        Done        = 1'b0;
        MisalignErr = 1'b0;
        BusErr      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Req) begin
                    if (is_misaligned(size_e'(Size), Addr[1:0])) begin
                        MisalignErr = 1'b1;
                    end else begin
                        // Stall is raised combinationally so the pipeline
                        // freezes in the very cycle the request is seen.
                        Stall    = 1'b1;
                        we_d     = WE;
                        size_d   = size_e'(Size);
                        ext_d    = Ext;
                        addr_d   = Addr;
                        wdata_d  = WData;
                        cnt_d    = '0;
                        err_d    = 1'b0;
                        busreq_d = 1'b1;
                        state_d  = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                Stall = 1'b1;
                if (bus.BusAck) begin
                    rdata_d  = we_q ? '0 : ld_data;
                    busreq_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_DONE;
                end else if (cnt_inc == TIMEOUT_W'(TIMEOUT)) begin
                    // BusReq has now been high for exactly TIMEOUT cycles.
                    rdata_d  = '0;
                    busreq_d = 1'b0;
                    err_d    = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE: begin
                Done    = 1'b1;
                BusErr  = err_q;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            size_q   <= SZ_BYTE;
            ext_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            busreq_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            ext_q    <= ext_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            busreq_q <= busreq_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign RData        = rdata_q;
    assign bus.BusReq   = busreq_q;
    assign bus.BusWE    = busreq_q & we_q;
    assign bus.BusBE    = busreq_q ? be : BE_NONE;
    assign bus.BusAddr  = {addr_q[31:2], 2'b00};
    assign bus.BusWData = bus_wdata;

endmodule

// File: tb/tb_dmem_controller.sv
// Scoreboard bench for dmem_controller: the stimulus process issues requests,
// plays the bus slave and pushes the reference-model response; a negedge
// monitor pops and compares whenever the DUT shows BusReq, Done or MisalignErr.
module tb_dmem_controller;

    localparam int unsigned TO = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Req = 1'b0;
    logic        WE = 1'b0;
    logic [1:0]  Size = 2'b00;
    logic        Ext = 1'b0;
    logic [31:0] Addr = '0;
    logic [31:0] WData = '0;
    logic [31:0] RData;
    logic        Done, Stall, MisalignErr, BusErr;

    dmem_controller_if bus_if();

    dmem_controller #(.TIMEOUT(TO), .TIMEOUT_W(8)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .Req         (Req),
        .WE          (WE),
        .Size        (Size),
        .Ext         (Ext),
        .Addr        (Addr),
        .WData       (WData),
        .RData       (RData),
        .Done        (Done),
        .Stall       (Stall),
        .MisalignErr (MisalignErr),
        .BusErr      (BusErr),
        .bus         (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;       // 0 transaction, 1 misaligned, 2 aborted by reset
        logic [31:0] rdata;
        logic        err;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] bwdata;
        int unsigned req_cycles;
    } exp_t;

    exp_t q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: works on lane byte arrays and byte counts.
    function automatic exp_t model(input logic we, input logic [1:0] size, input logic ext,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] brd, input int unsigned delay);
        exp_t        e;
        int unsigned n, off;
        logic [7:0]  lanes [4];
        logic [63:0] v;
        e.kind = 0; e.rdata = '0; e.err = 1'b0; e.be = '0; e.bwdata = '0;
        e.we = we; e.baddr = addr & ~32'd3;
        e.req_cycles = (delay == 0) ? TO : delay;
        if (size == 2'b11) begin
            e.kind = 1;
            return e;
        end
        n = 1 << size;
        off = addr % 4;
        if (off % n != 0) begin
            e.kind = 1;
            return e;
        end
        for (int unsigned i = 0; i < 4; i++) lanes[i] = 8'(brd >> (8 * (3 - i)));
        for (int unsigned i = off; i < off + n; i++) e.be = e.be | 4'(1 << (3 - i));
        for (int unsigned i = 0; i < 4; i++)
            e.bwdata = e.bwdata | (32'(8'(wdata >> (8 * (n - 1 - (i % n))))) << (8 * (3 - i)));
        v = '0;
        for (int unsigned j = 0; j < n; j++) v = (v << 8) | 64'(lanes[off + j]);
        if (ext && v[8 * n - 1]) v = v | (~64'd0 << (8 * n));
        e.err = (delay == 0);
        e.rdata = (we || delay == 0) ? 32'd0 : v[31:0];
        return e;
    endfunction

    // delay = number of BusReq cycles up to and including the ack; 0 = never ack.
    task automatic do_txn(input logic we, input logic [1:0] size, input logic ext,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] brd, input int unsigned delay);
        exp_t        e;
        int unsigned g;
        e = model(we, size, ext, addr, wdata, brd, delay);
        q.push_back(e);
        @(posedge clk); #1;
        Req = 1'b1; WE = we; Size = size; Ext = ext; Addr = addr; WData = wdata;
        @(posedge clk); #1;
        Req = 1'b0; WE = $urandom % 2; Addr = $urandom; WData = $urandom;
        if (e.kind == 1) return;
        if (delay == 0) begin
            g = 0;
            while (bus_if.BusReq === 1'b1 && g < TO + 10) begin
                bus_if.BusRData = $urandom;
                @(posedge clk); #1;
                g++;
            end
            check("timeout_bound", 32'(g < TO + 10), 32'd1);
        end else begin
            for (int unsigned k = 1; k <= delay; k++) begin
                if (k == delay) begin
                    bus_if.BusAck = 1'b1;
                    bus_if.BusRData = brd;
                end else begin
                    bus_if.BusRData = $urandom;
                end
                @(posedge clk); #1;
            end
            bus_if.BusAck = 1'b0;
            bus_if.BusRData = $urandom;
        end
    endtask

    // Monitor / scoreboard
    int unsigned stall_cnt = 0;
    int unsigned req_cnt = 0;
    logic        req_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_cnt = 0; req_cnt = 0; req_prev = 1'b0;
            if (q.size() > 0 && q[0].kind == 2) void'(q.pop_front());
        end else begin
            if (Stall) stall_cnt++;
            if (bus_if.BusReq) req_cnt++;
            if (BusErr && !Done) check("buserr_without_done", 32'(Done), 32'd1);
            if (bus_if.BusReq && !req_prev) begin
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_busreq: got BusReq=1 expected no request");
                end else begin
                    e = q[0];
                    check("bus_addr", bus_if.BusAddr, e.baddr);
                    check("bus_be", 32'(bus_if.BusBE), 32'(e.be));
                    check("bus_we", 32'(bus_if.BusWE), 32'(e.we));
                    if (e.we) check("bus_wdata", bus_if.BusWData, e.bwdata);
                end
            end
            if (MisalignErr || Done) begin
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_response: got Done=%0b MisalignErr=%0b expected none",
                             Done, MisalignErr);
                end else begin
                    e = q.pop_front();
                    if (MisalignErr) begin
                        check("misalign_expected", 32'(e.kind), 32'd1);
                        check("misalign_stall", 32'(Stall), 32'd0);
                        check("misalign_busreq", 32'(bus_if.BusReq), 32'd0);
                        check("misalign_done", 32'(Done), 32'd0);
                    end else begin
                        check("done_expected", 32'(e.kind), 32'd0);
                        check("rdata", RData, e.rdata);
                        check("buserr", 32'(BusErr), 32'(e.err));
                        check("done_stall_low", 32'(Stall), 32'd0);
                        check("stall_cycles", stall_cnt, e.req_cycles + 1);
                        check("busreq_cycles", req_cnt, e.req_cycles);
                    end
                end
                stall_cnt = 0;
                req_cnt = 0;
            end
            req_prev = bus_if.BusReq;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t        e;
        logic [1:0]  sz;
        logic [31:0] a;
        bus_if.BusAck = 1'b0;
        bus_if.BusRData = '0;
        #1;
        check("rst_busreq", 32'(bus_if.BusReq), 32'd0);
        check("rst_buswe", 32'(bus_if.BusWE), 32'd0);
        check("rst_busbe", 32'(bus_if.BusBE), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_misalign", 32'(MisalignErr), 32'd0);
        check("rst_buserr", 32'(BusErr), 32'd0);
        check("rst_rdata", RData, 32'd0);
        check("rst_busaddr", bus_if.BusAddr, 32'd0);
        check("rst_buswdata", bus_if.BusWData, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed cases
        do_txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3);
        do_txn(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h000000F0, 1);
        do_txn(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h000000F0, 2);
        do_txn(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 32'h12345678, 2);
        do_txn(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1);
        do_txn(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 1);
        do_txn(1'b0, 2'b01, 1'b1, 32'h302, 32'h0, 32'h1234_8001, 1);
        do_txn(1'b0, 2'b10, 1'b1, 32'h400, 32'h0, 32'h8000_0001, 0);

        // Reset in the middle of REQ, then a spurious ack while idle
        e = model(1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 32'h0, 4);
        e.kind = 2;
        q.push_back(e);
        @(posedge clk); #1;
        Req = 1'b1; WE = 1'b0; Size = 2'b10; Ext = 1'b0; Addr = 32'h500;
        @(posedge clk); #1;
        Req = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_busreq", 32'(bus_if.BusReq), 32'd0);
        check("abort_stall", 32'(Stall), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_busaddr", bus_if.BusAddr, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        bus_if.BusAck = 1'b1; bus_if.BusRData = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus_if.BusAck = 1'b0;
        check("spurious_ack_rdata", RData, 32'd0);
        do_txn(1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 32'h0BADF00D, 2);

        // Randomized traffic
        for (int unsigned t = 0; t < 40; t++) begin
            sz = ($urandom % 5 == 0) ? 2'b11 : 2'($urandom % 3);
            a = $urandom;
            if ($urandom % 3 != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
            do_txn(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom,
                   $urandom_range(1, 6));
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
